// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI widths, manager index type and manager count
package obi_pkg;
  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int NUM_MGR = 2;
  typedef logic mgr_idx_t;
endpackage

// File: rtl/obi_owner_fifo.sv
// obi_owner_fifo: tracks which manager owns each outstanding transaction, in issue order
module obi_owner_fifo
  import obi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  logic     pop,
  input  mgr_idx_t din,
  output mgr_idx_t head,
  output logic     full,
  output logic     empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  mgr_idx_t mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign head = mem[rd_q];
  always_ff @(posedge clk_i) if (do_push) mem[wr_q] <= din;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: 2-manager round-robin OBI arbiter with grant lock and in-order response routing
module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int ADDR_W = OBI_ADDR_W,
  parameter int DATA_W = OBI_DATA_W,
  parameter int MAX_OUTST = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_MGR-1:0]          mgr_req_i,
  output logic [NUM_MGR-1:0]          mgr_gnt_o,
  input  logic [NUM_MGR*ADDR_W-1:0]   mgr_addr_i,
  input  logic [NUM_MGR-1:0]          mgr_we_i,
  input  logic [NUM_MGR*DATA_W/8-1:0] mgr_be_i,
  input  logic [NUM_MGR*DATA_W-1:0]   mgr_wdata_i,
  output logic [NUM_MGR-1:0]          mgr_rvalid_o,
  output logic [DATA_W-1:0]           mgr_rdata_o,
  output logic                        slv_req_o,
  input  logic                        slv_gnt_i,
  output logic [ADDR_W-1:0]           slv_addr_o,
  output logic                        slv_we_o,
  output logic [DATA_W/8-1:0]         slv_be_o,
  output logic [DATA_W-1:0]           slv_wdata_o,
  input  logic                        slv_rvalid_i,
  input  logic [DATA_W-1:0]           slv_rdata_i,
  output logic                        busy_o,
  output logic                        resp_err_o
);
  localparam int BE_W = DATA_W / 8;
  mgr_idx_t sel, last_q, lock_sel_q, head;
  logic lock_q, act, accept, rsp, full, empty;
  assign sel = lock_q ? lock_sel_q :
               mgr_req_i == 2'b11 ? !last_q : mgr_req_i[1];
  // reset gating keeps every handshake output low while rst_ni is held
  assign act = rst_ni & mgr_req_i[sel];
  assign slv_req_o = act & !full;
  assign accept = slv_req_o & slv_gnt_i;
  assign slv_addr_o = act ? mgr_addr_i[int'(sel)*ADDR_W +: ADDR_W] : '0;
  assign slv_we_o = act & mgr_we_i[sel];
  assign slv_be_o = act ? mgr_be_i[int'(sel)*BE_W +: BE_W] : '0;
  assign slv_wdata_o = act ? mgr_wdata_i[int'(sel)*DATA_W +: DATA_W] : '0;
  assign mgr_gnt_o = accept ? NUM_MGR'(1) << sel : '0;
  assign rsp = rst_ni & slv_rvalid_i & !empty;
  assign mgr_rvalid_o = rsp ? NUM_MGR'(1) << head : '0;
  assign mgr_rdata_o = slv_rdata_i;
  assign resp_err_o = rst_ni & slv_rvalid_i & empty;
  assign busy_o = !empty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      lock_sel_q <= 1'b0;
      last_q <= 1'b1;
    end else if (accept) begin
      lock_q <= 1'b0;
      last_q <= sel;
    end else if (slv_req_o) begin
      lock_q <= 1'b1;
      lock_sel_q <= sel;
    end
  end
  obi_owner_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push(accept),
    .pop(rsp),
    .din(sel),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed and random stimulus checked against a queue-based arbiter model
module tb_obi_rr_arbiter;
  localparam int MAX = 2;
  logic clk_i = 0, rst_ni = 0;
  logic [1:0] mgr_req = 0, mgr_gnt, mgr_we = 0, mgr_rvalid;
  logic [63:0] mgr_addr = 0, mgr_wdata = 0;
  logic [7:0] mgr_be = 0;
  logic [31:0] mgr_rdata, slv_addr, slv_wdata, slv_rdata = 0;
  logic slv_req, slv_gnt = 0, slv_we, slv_rvalid = 0, busy, resp_err;
  logic [3:0] slv_be;
  int n_chk = 0, n_pass = 0;
  int q[$];
  int last = 1, pend = -1;
  obi_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mgr_req_i(mgr_req), .mgr_gnt_o(mgr_gnt), .mgr_addr_i(mgr_addr), .mgr_we_i(mgr_we),
    .mgr_be_i(mgr_be), .mgr_wdata_i(mgr_wdata), .mgr_rvalid_o(mgr_rvalid), .mgr_rdata_o(mgr_rdata),
    .slv_req_o(slv_req), .slv_gnt_i(slv_gnt), .slv_addr_o(slv_addr), .slv_we_o(slv_we),
    .slv_be_o(slv_be), .slv_wdata_o(slv_wdata), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata),
    .busy_o(busy), .resp_err_o(resp_err)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic model_reset();
    q.delete();
    last = 1;
    pend = -1;
  endtask
  task automatic do_reset();
    rst_ni = 0;
    mgr_req = 0;
    slv_gnt = 0;
    slv_rvalid = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_slv_req", slv_req, 0);
    chk("rst_gnt", mgr_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", mgr_rvalid, 0);
    chk("rst_err", resp_err, 0);
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();
  endtask
  task automatic cycle(input logic [1:0] req, input logic g, input logic rv);
    int own;
    logic sreq, acc;
    @(posedge clk_i);
    #1;
    mgr_req = req;
    slv_gnt = g;
    slv_rvalid = rv;
    #1;
    own = pend >= 0 ? pend : req == 2'b11 ? 1 - last : req[1] ? 1 : req[0] ? 0 : -1;
    sreq = own >= 0 && req[own] && q.size() < MAX;
    acc = sreq && g;
    chk("slv_req", slv_req, sreq);
    chk("mgr_gnt", mgr_gnt, acc ? 1 << own : 0);
    if (sreq) begin
      chk("slv_addr", slv_addr, mgr_addr[own*32 +: 32]);
      chk("slv_wdata", slv_wdata, mgr_wdata[own*32 +: 32]);
      chk("slv_we", slv_we, mgr_we[own]);
      chk("slv_be", slv_be, mgr_be[own*4 +: 4]);
    end
    chk("mgr_rvalid", mgr_rvalid, rv && q.size() > 0 ? 1 << q[0] : 0);
    chk("resp_err", resp_err, rv && q.size() == 0);
    chk("busy", busy, q.size() > 0);
    if (rv && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      q.push_back(own);
      last = own;
      pend = -1;
    end else if (sreq) pend = own;
  endtask
  initial begin
    logic [1:0] r;
    do_reset();
    mgr_addr = {32'h2000_0000, 32'h1000_0000};
    slv_rdata = 32'hA5;
    cycle(2'b01, 1, 0);
    chk("t1_addr", slv_addr, 64'h1000_0000);
    chk("t1_gnt", mgr_gnt, 2'b01);
    cycle(2'b00, 0, 1);
    chk("t1_rvalid", mgr_rvalid, 2'b01);
    chk("t1_rdata", mgr_rdata, 32'hA5);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 1, i > 0);
      chk("alt_gnt", mgr_gnt, i % 2 ? 2'b10 : 2'b01);
    end
    do_reset();
    cycle(2'b10, 0, 0);
    cycle(2'b11, 0, 0);
    chk("lock_addr", slv_addr, mgr_addr[63:32]);
    cycle(2'b11, 0, 0);
    cycle(2'b11, 1, 0);
    chk("lock_first", mgr_gnt, 2'b10);
    cycle(2'b01, 1, 1);
    chk("lock_second", mgr_gnt, 2'b01);
    do_reset();
    cycle(2'b01, 1, 0);
    cycle(2'b10, 1, 0);
    cycle(2'b01, 1, 0);
    chk("full_req", slv_req, 0);
    cycle(2'b01, 1, 1);
    chk("full_rvalid", mgr_rvalid, 2'b01);
    chk("full_nobypass", mgr_gnt, 2'b00);
    cycle(2'b01, 1, 0);
    chk("full_accept", mgr_gnt, 2'b01);
    do_reset();
    cycle(2'b00, 0, 1);
    chk("err_pulse", resp_err, 1);
    cycle(2'b00, 0, 0);
    chk("err_clear", resp_err, 0);
    do_reset();
    cycle(2'b01, 1, 0);
    cycle(2'b10, 1, 0);
    mgr_req = 2'b11;
    #1;
    rst_ni = 0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_gnt", mgr_gnt, 0);
    chk("mid_req", slv_req, 0);
    mgr_req = 0;
    slv_gnt = 0;
    #1;
    rst_ni = 1;
    model_reset();
    cycle(2'b00, 0, 1);
    chk("mid_err", resp_err, 1);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 2'($urandom);
      if (pend >= 0) r[pend] = 1'b1;
      mgr_addr = {$urandom, $urandom};
      mgr_wdata = {$urandom, $urandom};
      mgr_we = 2'($urandom);
      mgr_be = 8'($urandom);
      slv_rdata = $urandom;
      cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
